enc_link_tx: RTL and testbench

Downstream stage of the 8-to-3 encoder. It accepts each encoded 3-bit code, with the encoder's a3 flag used as the valid strobe, and buffers codes in a small FIFO. It then serialises each code onto a single transmit line as a framed, parity-protected word, so the encoded information crosses the link on one wire.

---
 rtl/enc_link_pkg.sv | 12 +
 rtl/enc_link_if.sv | 24 ++
 rtl/enc_link_fifo.sv | 45 ++++
 rtl/enc_link_tx.sv | 133 +++++++++++++
 tb/tb_enc_link_tx.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/enc_link_pkg.sv
// rtl/enc_link_pkg.sv - shared types and frame constants for the encoded-code serial link
package enc_link_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  localparam int   FRAME_BITS  = 6;
  localparam int   DATA_BITS   = 3;
  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/enc_link_if.sv
// rtl/enc_link_if.sv - code input handshake plus serial line and status bundle
interface enc_link_if;
  import enc_link_pkg::*;

  logic                 in_valid;
  logic [DATA_BITS-1:0] in_code;
  logic                 in_ready;
  logic                 tx_line;
  logic                 busy;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 overflow_err;

  modport master (
    output in_valid, in_code,
    input  in_ready, tx_line, busy, fifo_full, fifo_empty, overflow_err
  );

  modport slave (
    input  in_valid, in_code,
    output in_ready, tx_line, busy, fifo_full, fifo_empty, overflow_err
  );

endinterface

// File: rtl/enc_link_fifo.sv
// rtl/enc_link_fifo.sv - DEPTH x 3 code FIFO; pointers carry an extra wrap bit
module enc_link_fifo
  import enc_link_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  output logic [DATA_BITS-1:0] rdata_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic                 do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  // Same slot index with differing wrap bits means the writer lapped the reader.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

endmodule

// File: rtl/enc_link_tx.sv
// rtl/enc_link_tx.sv - buffers encoder codes and sends each as a start/3-data/parity/stop frame
module enc_link_tx
  import enc_link_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  enc_link_if.slave  link
);

  state_e               state_q, state_d;
  logic [7:0]           timer_q, timer_d;
  logic [1:0]           bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ovf_q;

  logic                 push, pop, full, empty, bit_end;
  logic [DATA_BITS-1:0] head;

  enc_link_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (link.in_code),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign push    = link.in_valid && !full;
  assign bit_end = (timer_q == 8'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= LINE_IDLE;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      if (link.in_valid && full) ovf_q <= 1'b1;
    end
  end

  // tx_d is the level of the bit that begins at the coming edge, so tx_line stays registered.
  always_comb begin
    state_d  = state_q;
    timer_d  = (state_q == IDLE || bit_end) ? 8'd0 : timer_q + 8'd1;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    tx_d     = tx_q;
    pop      = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = LINE_IDLE;
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head;
          par_d   = ^head;
          state_d = START;
          tx_d    = START_LEVEL;
        end
      end
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          bitcnt_d = '0;
          tx_d     = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bitcnt_q == 2'(DATA_BITS - 1)) begin
            state_d  = PARITY;
            bitcnt_d = '0;
            tx_d     = par_q;
          end else begin
            bitcnt_d = bitcnt_q + 2'd1;
            shreg_d  = shreg_q >> 1;
            tx_d     = shreg_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = STOP_LEVEL;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = head;
            par_d   = ^head;
            state_d = START;
            tx_d    = START_LEVEL;
          end else begin
            state_d = IDLE;
            tx_d    = LINE_IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
      end
    endcase
  end

  assign link.in_ready     = !full;
  assign link.tx_line      = tx_q;
  assign link.busy         = (state_q != IDLE);
  assign link.fifo_full    = full;
  assign link.fifo_empty   = empty;
  assign link.overflow_err = ovf_q;

endmodule

// File: tb/tb_enc_link_tx.sv
// tb/tb_enc_link_tx.sv - directed and random code traffic against a frame-timeline reference model
module tb_enc_link_tx;
  import enc_link_pkg::*;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = FRAME_BITS * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  enc_link_if link();

  enc_link_tx #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (link)
  );

  int checks = 0;
  int errors = 0;

  // Model: pending codes, the frame on the wire and when it started.
  logic [2:0] pend[$];
  bit         m_active;
  int         m_start;
  logic [2:0] m_code;
  bit         m_ovf;
  int         cyc;

  function automatic logic frame_bit(logic [2:0] c, int k);
    logic [FRAME_BITS-1:0] f;
    f = {STOP_LEVEL, ^c, c, START_LEVEL};
    return f[k];
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_active = 1'b0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_edge(bit v, logic [2:0] c);
    bit pre_full;
    cyc++;
    pre_full = (pend.size() == DEPTH);
    if (m_active && (cyc - m_start == FRAME)) m_active = 1'b0;
    if (!m_active && pend.size() != 0) begin
      m_code   = pend.pop_front();
      m_active = 1'b1;
      m_start  = cyc;
    end
    if (v) begin
      if (!pre_full) pend.push_back(c);
      else           m_ovf = 1'b1;
    end
  endtask

  task automatic check_outputs();
    logic exp_line;
    exp_line = m_active ? frame_bit(m_code, (cyc - m_start) / DIV) : LINE_IDLE;
    chk("tx_line",      8'(link.tx_line),      8'(exp_line));
    chk("busy",         8'(link.busy),         8'(m_active));
    chk("fifo_empty",   8'(link.fifo_empty),   8'(pend.size() == 0));
    chk("fifo_full",    8'(link.fifo_full),    8'(pend.size() == DEPTH));
    chk("in_ready",     8'(link.in_ready),     8'(pend.size() < DEPTH));
    chk("overflow_err", 8'(link.overflow_err), 8'(m_ovf));
  endtask

  task automatic step(bit v, logic [2:0] c);
    link.in_valid = v;
    link.in_code  = c;
    @(posedge clk);
    model_edge(v, c);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 3'b000);
  endtask

  // Reset is raised between edges so the line must return high without a clock.
  task automatic async_reset(int ncyc);
    link.in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_tx_line",    8'(link.tx_line),      8'(1));
    chk("rst_busy",       8'(link.busy),         8'(0));
    chk("rst_fifo_empty", 8'(link.fifo_empty),   8'(1));
    chk("rst_in_ready",   8'(link.in_ready),     8'(1));
    chk("rst_overflow",   8'(link.overflow_err), 8'(0));
    model_reset();
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
  endtask

  initial begin
    link.in_valid = 1'b0;
    link.in_code  = 3'b000;
    cyc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
    idle(2);

    async_reset(3);
    idle(2);

    step(1'b1, 3'b101);
    idle(FRAME + 4);

    step(1'b1, 3'b111);
    idle(FRAME + 4);
    step(1'b1, 3'b000);
    idle(FRAME + 4);

    for (int i = 1; i <= 4; i++) step(1'b1, 3'(i));
    idle(4 * FRAME + 4);

    for (int i = 0; i < 6; i++) step(1'b1, 3'($urandom_range(0, 7)));
    idle(6 * FRAME + 4);

    repeat (60) step($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)));
    idle((DEPTH + 1) * FRAME + 4);

    step(1'b1, 3'($urandom_range(0, 7)));
    idle(DIV + 3);
    async_reset(2);
    idle(FRAME + 6);
    step(1'b1, 3'b110);
    idle(FRAME + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
